// File: rtl/result_drain.sv
// Drains the M x N2 result matrix from data memory after the CPU signals done,
// streaming it row-major over valid/ready with a running wrapping checksum.
module result_drain #(
    parameter int unsigned M      = 100,
    parameter int unsigned N      = 50,
    parameter int unsigned N2     = 2,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col,
    output logic              out_last,
    output logic [WIDTH-1:0]  checksum,
    output logic              busy,
    output logic              finished
);

    localparam longint unsigned BASE_L = 64'(M) * 64'(N) + 64'(N) * 64'(N2);
    localparam longint unsigned END_L  = BASE_L + 64'(M) * 64'(N2);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_L);
    localparam logic [15:0] LAST_I = 16'(M - 1);
    localparam logic [15:0] LAST_J = 16'(N2 - 1);

    // Result block must fit inside the memory's word-address space.
    generate
        if (END_L > (64'd1 << ADDR_W)) begin : g_addr_range_err
            $error("result_drain: BASE + M*N2 exceeds 2^ADDR_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SEND,
        S_FIN
    } state_t;

    state_t state, state_n;

    logic              done_q;
    logic              start_c;
    logic [15:0]       i_q, j_q, i_n, j_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W-1:0] rd_addr_n;
    logic [WIDTH-1:0]  data_n, chk_n;
    logic [15:0]       row_n, col_n;
    logic              last_n;

    assign start_c = done & ~done_q;

    // Next-state and datapath next values.
    always_comb begin
        state_n   = state;
        i_n       = i_q;
        j_n       = j_q;
        addr_n    = addr_q;
        rd_addr_n = rd_addr;
        data_n    = out_data;
        chk_n     = checksum;
        row_n     = out_row;
        col_n     = out_col;
        last_n    = out_last;
        case (state)
            S_IDLE, S_FIN: begin
                if (start_c) begin
                    i_n     = '0;
                    j_n     = '0;
                    addr_n  = BASE;
                    chk_n   = '0;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                data_n  = rd_data;
                row_n   = i_q;
                col_n   = j_q;
                last_n  = (i_q == LAST_I) && (j_q == LAST_J);
                state_n = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    chk_n = checksum + out_data;
                    if (out_last) begin
                        state_n = S_FIN;
                    end else begin
                        if (j_q == LAST_J) begin
                            j_n = '0;
                            i_n = i_q + 16'd1;
                        end else begin
                            j_n = j_q + 16'd1;
                        end
                        addr_n  = addr_q + ADDR_W'(1);
                        state_n = S_ISSUE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (state_n == S_ISSUE) begin
            rd_addr_n = addr_n;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered outputs decoded from the upcoming state.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            done_q    <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            addr_q    <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            checksum  <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
        end else begin
            done_q    <= done;
            i_q       <= i_n;
            j_q       <= j_n;
            addr_q    <= addr_n;
            rd_en     <= (state_n == S_ISSUE);
            rd_addr   <= rd_addr_n;
            out_valid <= (state_n == S_SEND);
            out_data  <= data_n;
            out_row   <= row_n;
            out_col   <= col_n;
            out_last  <= last_n;
            checksum  <= chk_n;
            busy      <= (state_n inside {S_ISSUE, S_WAIT, S_SEND});
            finished  <= (state_n == S_FIN);
        end
    end

endmodule
